mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
// - Round-robin arbiter sharing the 3-source, WIDTH-bit 4:1 mux path among requesters 0..2.
// - Source mapping: requester 0 = a1, 1 = a2, 2 = a3.
// - Drives select s (00=a1, 01=a2, 10=a3, 11=idle) and one-hot grant gnt.
// - Registers the selected source onto y with a valid flag, so downstream logic sees one clean owner per cycle.
// PARAMETERS
// - WIDTH     8  data width of a1/a2/a3/y
// - MAX_HOLD  4  max consecutive grant cycles per owner when timeout compiled in; legal range >= 1
// PORTS
// - clk      input   1      clock; all state updates on rising edge
// - reset    input   1      synchronous, active-high reset
// - req      input   3      request per requester; bit i = requester i; level-sensitive
// - a1       input   WIDTH  source data, requester 0
// - a2       input   WIDTH  source data, requester 1
// - a3       input   WIDTH  source data, requester 2
// - s        output  2      registered mux select; 2'b11 when idle
// - gnt      output  3      registered one-hot grant; 3'b000 when idle
// - y        output  WIDTH  registered data from current owner's source
// - y_valid  output  1      1 when y holds data from a granted owner
// BEHAVIOUR
// - Reset values: s=2'b11, gnt=3'b000, y=0, y_valid=0, state=IDLE, last=2, hold_cnt=0. Requester 0 therefore wins first after reset.
// - Reset applied mid-grant: same values at the next edge; any in-flight grant is dropped.
// - States:
//   - IDLE: any req -> GRANT, picking the winner by round-robin.
//   - GRANT: stays with the owner while req[owner]=1.
// - Round-robin: search starts at (last+1) mod 3 and wraps. On each new grant, last <= winner.
// - Latency: 1 cycle from req sampled high to gnt/s/y_valid asserted.
//   - y captures the winner's source on that same edge.
//   - While in GRANT, y <= owner's source every cycle.
// - Owner drops req: at that edge, arbitrate among the other requests.
//   - Any pending: switch directly, with no idle cycle.
//   - None pending: go to IDLE, with s=11, gnt=0, y_valid=0; y holds its last value.
// - Simultaneous requests: exactly one grant, resolved by round-robin order. gnt is always one-hot or zero.
// - Requests with req held high never starve: each waits at most 2 owner tenures.
// - hold_cnt: width $clog2(MAX_HOLD+1).
//   - Cleared on every new grant.
//   - Increments each cycle in GRANT and saturates at MAX_HOLD.
// - gnt/s/y/y_valid change only on clock edges; no combinational path from req to outputs.
// CONFIGURATION
// - Macro: MUX4_ARB_TIMEOUT_EN.
// - Defined:
//   - When hold_cnt == MAX_HOLD-1 and another requester is pending, the next edge forces a rotate to the next round-robin winner.
//   - If no other requester is pending, the owner keeps the grant and hold_cnt restarts at 0.
// - Undefined:
//   - No forced release; the owner keeps the grant until its req drops.
//   - hold_cnt logic is omitted.
// TESTING
// - Reset check: assert reset 2 cycles -> s=11, gnt=000, y=00, y_valid=0.
// - Single requester: a1=FF, a2=0F, a3=33; req=001 -> next edge gnt=001, s=00, y=FF, y_valid=1.
// - Rotation: req=111 from reset -> gnt=001 (y=FF).
//   - Drop req0 -> gnt=010, s=01, y=0F.
//   - Drop req1 -> gnt=100, s=10, y=33.
//   - Drop req2 -> s=11, y_valid=0, y stays 33.
// - Timeout (macro defined, MAX_HOLD=4): req=011 held -> gnt 001 for 4 cycles, 010 for 4, then 001 again; alternates with no gap.
// - No timeout (macro undefined): req=011 held 20 cycles -> gnt stays 001 throughout.
// - Reset mid-grant: with gnt=010, pulse reset 1 cycle while req=111 -> s=11, gnt=000, then gnt=001 on the next edge.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for three requesters sharing a WIDTH-bit 4:1 mux path, with registered select, grant and data outputs.
// Define MUX4_ARB_TIMEOUT_EN to force the grant to rotate after MAX_HOLD cycles when another requester is waiting.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    output logic [1:0]       s,
    output logic [2:0]       gnt,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       last_reg, last_next;
    logic [1:0]       s_reg, s_next;
    logic [2:0]       gnt_reg, gnt_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic             y_valid_reg, y_valid_next;
    logic [WIDTH-1:0] src_next;
    logic [2:0]       owner_mask;
    logic [2:0]       others;
    logic             owner_req;
    logic             new_grant;
    logic [1:0]       pick_all, pick_others;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be >= 1");
    end

    // last_reg doubles as the current owner while in GRANT
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_owner
            assign owner_mask[gi] = (last_reg == 2'(gi));
        end
    endgenerate

    assign owner_req = |(req & owner_mask);
    assign others    = req & ~owner_mask;

    // First set bit of mask searching from last+1, wrapping through 0..2
    function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
        logic [1:0] c0, c1, c2;
        case (last)
            2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
            2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
            default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
        endcase
        if (mask[c0])      return c0;
        else if (mask[c1]) return c1;
        else               return c2;
    endfunction

    assign pick_all    = rr_pick(req, last_reg);
    assign pick_others = rr_pick(others, last_reg);

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              hold_expired;

    assign hold_expired = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));

    // A lone owner reaching the limit keeps the bus and starts a fresh window
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (new_grant) begin
            hold_cnt_next = '0;
        end else if (state_reg == GRANT) begin
            if (hold_expired)
                hold_cnt_next = '0;
            else if (hold_cnt_reg != HOLD_W'(MAX_HOLD))
                hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            hold_cnt_reg <= '0;
        else
            hold_cnt_reg <= hold_cnt_next;
    end
`endif

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        new_grant  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    last_next  = pick_all;
                    new_grant  = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (|req) begin
                        last_next = pick_all;
                        new_grant = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
`ifdef MUX4_ARB_TIMEOUT_EN
                else if (hold_expired && (|others)) begin
                    last_next = pick_others;
                    new_grant = 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (last_next)
            2'd0:    src_next = a1;
            2'd1:    src_next = a2;
            default: src_next = a3;
        endcase
        s_next       = 2'b11;
        gnt_next     = 3'b000;
        y_next       = y_reg;
        y_valid_next = 1'b0;
        if (state_next == GRANT) begin
            s_next       = last_next;
            gnt_next     = 3'b001 << last_next;
            y_next       = src_next;
            y_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            last_reg    <= 2'd2;
            s_reg       <= 2'b11;
            gnt_reg     <= 3'b000;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            s_reg       <= s_next;
            gnt_reg     <= gnt_next;
            y_reg       <= y_next;
            y_valid_reg <= y_valid_next;
        end
    end

    assign s       = s_reg;
    assign gnt     = gnt_reg;
    assign y       = y_reg;
    assign y_valid = y_valid_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, hold/timeout sequences, then random traffic against a reference model.
// Follows MUX4_ARB_TIMEOUT_EN in the same way as the design.
module tb_mux4_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req;
    logic [WIDTH-1:0] a1, a2, a3;
    logic [1:0]       s;
    logic [2:0]       gnt;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    int n_cmp = 0;
    int n_bad = 0;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .s       (s),
        .gnt     (gnt),
        .y       (y),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = idle), last winner, data register
    int         m_owner;
    int         m_last;
    logic [7:0] m_y;
`ifdef MUX4_ARB_TIMEOUT_EN
    int         m_hold;
`endif

    function automatic int rr_winner(input logic [2:0] mask, input int last);
        for (int k = 1; k <= 3; k++)
            if (mask[(last + k) % 3]) return (last + k) % 3;
        return -1;
    endfunction

    function automatic logic [7:0] src_of(input int idx);
        if (idx == 0) return a1;
        if (idx == 1) return a2;
        return a3;
    endfunction

    task automatic model_step();
`ifdef MUX4_ARB_TIMEOUT_EN
        logic [2:0] oth;
`endif
        if (reset) begin
            m_owner = -1;
            m_last  = 2;
            m_y     = '0;
`ifdef MUX4_ARB_TIMEOUT_EN
            m_hold  = 0;
`endif
        end else begin
            if (m_owner < 0 || !req[m_owner]) begin
                m_owner = rr_winner(req, m_last);
                if (m_owner >= 0) begin
                    m_last = m_owner;
`ifdef MUX4_ARB_TIMEOUT_EN
                    m_hold = 0;
`endif
                end
            end else begin
`ifdef MUX4_ARB_TIMEOUT_EN
                oth = req;
                oth[m_owner] = 1'b0;
                if (m_hold == MAX_HOLD - 1) begin
                    if (oth != 3'b000) begin
                        m_owner = rr_winner(oth, m_last);
                        m_last  = m_owner;
                    end
                    m_hold = 0;
                end else if (m_hold < MAX_HOLD) begin
                    m_hold++;
                end
`endif
            end
            if (m_owner >= 0) m_y = src_of(m_owner);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] es, input logic [2:0] eg,
                         input logic [7:0] ey, input logic ev);
        n_cmp++;
        if (s !== es || gnt !== eg || y !== ey || y_valid !== ev) begin
            n_bad++;
            $display("FAIL %s: got s=%b gnt=%b y=%h y_valid=%b, expected s=%b gnt=%b y=%h y_valid=%b",
                     name, s, gnt, y, y_valid, es, eg, ey, ev);
        end else begin
            $display("ok   %s: s=%b gnt=%b y=%h y_valid=%b", name, s, gnt, y, y_valid);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] rq;
        logic [7:0] d1, d2, d3;
        logic [1:0] es;
        logic [2:0] eg;
        logic [7:0] ey;
        logic       ev;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [2:0] eg;
        logic [1:0] es;
        logic [7:0] ey;

        // reset | req | a1 a2 a3 | s gnt y y_valid
        vecs[0]  = '{1'b1, 3'b000, 8'hFF, 8'h0F, 8'h33, 2'b11, 3'b000, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 3'b000, 8'hFF, 8'h0F, 8'h33, 2'b11, 3'b000, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 8'hFF, 8'h0F, 8'h33, 2'b00, 3'b001, 8'hFF, 1'b1};
        vecs[3]  = '{1'b0, 3'b000, 8'hFF, 8'h0F, 8'h33, 2'b11, 3'b000, 8'hFF, 1'b0};
        vecs[4]  = '{1'b1, 3'b000, 8'hFF, 8'h0F, 8'h33, 2'b11, 3'b000, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 3'b111, 8'hFF, 8'h0F, 8'h33, 2'b00, 3'b001, 8'hFF, 1'b1};
        vecs[6]  = '{1'b0, 3'b110, 8'hFF, 8'h0F, 8'h33, 2'b01, 3'b010, 8'h0F, 1'b1};
        vecs[7]  = '{1'b0, 3'b100, 8'hFF, 8'h0F, 8'h33, 2'b10, 3'b100, 8'h33, 1'b1};
        vecs[8]  = '{1'b0, 3'b000, 8'hFF, 8'h0F, 8'h33, 2'b11, 3'b000, 8'h33, 1'b0};
        vecs[9]  = '{1'b1, 3'b000, 8'hFF, 8'h0F, 8'h33, 2'b11, 3'b000, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 3'b011, 8'hFF, 8'h0F, 8'h33, 2'b00, 3'b001, 8'hFF, 1'b1};
        vecs[11] = '{1'b0, 3'b110, 8'hFF, 8'h0F, 8'h33, 2'b01, 3'b010, 8'h0F, 1'b1};
        vecs[12] = '{1'b1, 3'b111, 8'hFF, 8'h0F, 8'h33, 2'b11, 3'b000, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 3'b111, 8'hFF, 8'h0F, 8'h33, 2'b00, 3'b001, 8'hFF, 1'b1};
        vecs[14] = '{1'b0, 3'b111, 8'h5A, 8'hC3, 8'h81, 2'b00, 3'b001, 8'h5A, 1'b1};

        reset = 1'b1;
        req   = 3'b000;
        a1    = '0;
        a2    = '0;
        a3    = '0;

        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst;
            req   = vecs[i].rq;
            a1    = vecs[i].d1;
            a2    = vecs[i].d2;
            a3    = vecs[i].d3;
            step();
            check($sformatf("vec%0d", i), vecs[i].es, vecs[i].eg, vecs[i].ey, vecs[i].ev);
        end

        // Two requesters held: alternating tenures with timeout, otherwise requester 0 keeps it
        reset = 1'b1; req = 3'b000; a1 = 8'hFF; a2 = 8'h0F; a3 = 8'h33;
        step();
        reset = 1'b0; req = 3'b011;
        for (int i = 0; i < 20; i++) begin
            step();
`ifdef MUX4_ARB_TIMEOUT_EN
            if (((i / MAX_HOLD) % 2) == 0) begin eg = 3'b001; es = 2'b00; ey = 8'hFF; end
            else                           begin eg = 3'b010; es = 2'b01; ey = 8'h0F; end
`else
            eg = 3'b001; es = 2'b00; ey = 8'hFF;
`endif
            check($sformatf("hold011_c%0d", i), es, eg, ey, 1'b1);
        end

        // Lone requester never loses the grant, timeout or not
        reset = 1'b1; req = 3'b000;
        step();
        reset = 1'b0; req = 3'b100;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("lone100_c%0d", i), 2'b10, 3'b100, 8'h33, 1'b1);
        end

        // Random traffic against the model
        reset = 1'b1; req = 3'b000;
        step();
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            a1 = 8'($urandom);
            a2 = 8'($urandom);
            a3 = 8'($urandom);
            step();
            if (m_owner < 0) begin es = 2'b11; eg = 3'b000; end
            else begin es = 2'(m_owner); eg = 3'(1 << m_owner); end
            check($sformatf("rand%0d", i), es, eg, m_y, m_owner >= 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
